// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: HD44780 init sequencer and command/character FIFO feeder.
// Optional `LCD_WAIT_CLEAR_EN: long post-command gap after clear/home.

module lcd_cmd_seq #(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_HZ     = 50_000_000,
    parameter int COLS       = 16,
    parameter int POR_US     = 15000,
    parameter int CMD_US     = 50,
    parameter int CLR_US     = 1600
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en_i,
    input  logic [8:0]                  wr_data_i,
    input  logic                        flush_i,
    output logic                        fifo_full_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o,
    output logic                        init_done_o,
    output logic                        lcd_req_o,
    output logic [7:0]                  lcd_data_o,
    output logic                        lcd_rs_o,
    input  logic                        lcd_done_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam longint MHZ = longint'(1_000_000);
    localparam longint POR_CYC = (longint'(CLK_HZ) * longint'(POR_US)) / MHZ;
    localparam longint CMD_CYC = (longint'(CLK_HZ) * longint'(CMD_US)) / MHZ;
    localparam longint CLR_CYC = (longint'(CLK_HZ) * longint'(CLR_US)) / MHZ;
    localparam longint MAX_A   = (POR_CYC > CMD_CYC) ? POR_CYC : CMD_CYC;
    localparam longint MAX_CYC = (MAX_A > CLR_CYC) ? MAX_A : CLR_CYC;
    localparam int CNT_W = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    // Counters run 0..N-1, so terminal values are the cycle counts minus one.
    localparam logic [CNT_W-1:0] POR_T = CNT_W'((POR_CYC > 0) ? POR_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CMD_T = CNT_W'((CMD_CYC > 0) ? CMD_CYC - 1 : 0);
    localparam logic [AW:0]      DEPTH_L  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]       COL_LAST = 8'(COLS - 1);

    typedef enum logic [2:0] {
        S_POR, S_INIT, S_IDLE, S_SEND, S_WAIT, S_GAP, S_WRAP
    } state_t;

    state_t state, state_nxt;

    logic [8:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [8:0]       head;
    logic             empty, push, pop;
    logic [CNT_W-1:0] cnt, gap_t, gap_sel;
    logic [2:0]       init_idx;
    logic [7:0]       col;
    logic             line, wrap_pend;

    assign fifo_level_o = wr_ptr - rd_ptr;
    assign fifo_full_o  = (fifo_level_o == DEPTH_L);
    assign empty        = (fifo_level_o == '0);
    assign head         = mem[rd_ptr[AW-1:0]];
    assign push         = wr_en_i && !fifo_full_o && !flush_i;
    assign pop          = (state == S_IDLE) && !empty;

`ifdef LCD_WAIT_CLEAR_EN
    localparam logic [CNT_W-1:0] CLR_T = CNT_W'((CLR_CYC > 0) ? CLR_CYC - 1 : 0);
    logic is_clear;
    assign is_clear = !lcd_rs_o && (lcd_data_o == 8'h01 || lcd_data_o == 8'h02);
    assign gap_sel  = is_clear ? CLR_T : CMD_T;
`else
    assign gap_sel  = CMD_T;
`endif

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        unique case (idx)
            3'd0:    init_byte = 8'h33;
            3'd1:    init_byte = 8'h32;
            3'd2:    init_byte = 8'h28;
            3'd3:    init_byte = 8'h0C;
            3'd4:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end

    // Flush takes priority over both push and pop, and never flags overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en_i && fifo_full_o) overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_POR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_POR:  if (cnt == POR_T) state_nxt = S_INIT;
            S_INIT: state_nxt = S_SEND;
            S_IDLE: if (!empty) state_nxt = S_SEND;
            S_SEND: state_nxt = S_WAIT;
            S_WAIT: if (lcd_done_i) state_nxt = S_GAP;
            S_GAP: begin
                if (cnt == gap_t) begin
                    if (wrap_pend)          state_nxt = S_WRAP;
                    else if (init_done_o)   state_nxt = S_IDLE;
                    else if (init_idx == 3'd6) state_nxt = S_IDLE;
                    else                    state_nxt = S_INIT;
                end
            end
            S_WRAP: state_nxt = S_SEND;
            default: state_nxt = S_POR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            gap_t       <= CMD_T;
            init_idx    <= '0;
            init_done_o <= 1'b0;
            lcd_req_o   <= 1'b0;
            lcd_data_o  <= '0;
            lcd_rs_o    <= 1'b0;
            col         <= '0;
            line        <= 1'b0;
            wrap_pend   <= 1'b0;
        end else begin
            if ((state == S_POR || state == S_GAP) && state_nxt == state)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (state_nxt == S_IDLE) init_done_o <= 1'b1;
            unique case (state)
                S_INIT: begin
                    lcd_data_o <= init_byte(init_idx);
                    lcd_rs_o   <= 1'b0;
                end
                S_IDLE: begin
                    if (!empty) begin
                        lcd_data_o <= head[7:0];
                        lcd_rs_o   <= head[8];
                    end
                end
                S_WRAP: begin
                    lcd_data_o <= line ? 8'hC0 : 8'h80;
                    lcd_rs_o   <= 1'b0;
                    wrap_pend  <= 1'b0;
                end
                S_SEND: lcd_req_o <= 1'b1;
                S_WAIT: begin
                    if (lcd_done_i) begin
                        lcd_req_o <= 1'b0;
                        gap_t     <= gap_sel;
                        if (!init_done_o) init_idx <= init_idx + 1'b1;
                        // Cursor follows the byte that just completed.
                        if (lcd_rs_o) begin
                            if (col >= COL_LAST) begin
                                col       <= '0;
                                line      <= !line;
                                wrap_pend <= 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else if (lcd_data_o == 8'h01 || lcd_data_o == 8'h02) begin
                            col  <= '0;
                            line <= 1'b0;
                        end else if (lcd_data_o[7:4] == 4'h8) begin
                            col  <= {4'h0, lcd_data_o[3:0]};
                            line <= 1'b0;
                        end else if (lcd_data_o[7:4] == 4'hC) begin
                            col  <= {4'h0, lcd_data_o[3:0]};
                            line <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq: random pushes checked against a queue-based byte/cursor model.
// Honours `LCD_WAIT_CLEAR_EN when checking post-clear gaps.

module tb_lcd_cmd_seq;

    localparam int D       = 16;
    localparam int CLK_HZ  = 1_000_000;
    localparam int COLS    = 16;
    localparam int POR_US  = 100;
    localparam int CMD_US  = 8;
    localparam int CLR_US  = 30;
    localparam int CPU     = CLK_HZ / 1_000_000;
    localparam int POR_CYC = POR_US * CPU;
    localparam int CMD_CYC = CMD_US * CPU;
    localparam int CLR_CYC = CLR_US * CPU;

    logic       clk, reset;
    logic       wr_en_i, flush_i, lcd_done_i;
    logic [8:0] wr_data_i;
    logic       fifo_full_o, overflow_o, init_done_o;
    logic [4:0] fifo_level_o;
    logic       lcd_req_o, lcd_rs_o;
    logic [7:0] lcd_data_o;

    lcd_cmd_seq #(
        .FIFO_DEPTH(D), .CLK_HZ(CLK_HZ), .COLS(COLS),
        .POR_US(POR_US), .CMD_US(CMD_US), .CLR_US(CLR_US)
    ) dut (
        .clk(clk), .reset(reset), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .flush_i(flush_i), .fifo_full_o(fifo_full_o), .fifo_level_o(fifo_level_o),
        .overflow_o(overflow_o), .init_done_o(init_done_o), .lcd_req_o(lcd_req_o),
        .lcd_data_o(lcd_data_o), .lcd_rs_o(lcd_rs_o), .lcd_done_i(lcd_done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Reference: every accepted byte in send order, with wrap commands inserted.
    logic [8:0] exp_q[$];
    int         m_col;
    bit         m_line;
    bit         auto_done;

    function automatic void model_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b});
        if (rs) begin
            m_col++;
            if (m_col >= COLS) begin
                m_col  = 0;
                m_line = !m_line;
                exp_q.push_back({1'b0, (m_line ? 8'hC0 : 8'h80)});
            end
        end else if (b == 8'h01 || b == 8'h02) begin
            m_col  = 0;
            m_line = 0;
        end else if (b >= 8'h80 && b <= 8'h8F) begin
            m_col  = int'(b - 8'h80);
            m_line = 0;
        end else if (b >= 8'hC0 && b <= 8'hCF) begin
            m_col  = int'(b - 8'hC0);
            m_line = 1;
        end
    endfunction

    function automatic int gap_need(input logic [8:0] prev);
`ifdef LCD_WAIT_CLEAR_EN
        if (prev == 9'h001 || prev == 9'h002) return CLR_CYC;
`endif
        return (prev === 9'h1FF) ? CMD_CYC : CMD_CYC;
    endfunction

    // Nibble-writer stand-in: done pulse two cycles into each request.
    initial begin
        int dly = 0;
        lcd_done_i = 1'b0;
        forever begin
            @(negedge clk);
            lcd_done_i = 1'b0;
            if (!reset || !lcd_req_o || !auto_done) begin
                dly = 0;
            end else if (dly == 1) begin
                lcd_done_i = 1'b1;
                dly = 0;
            end else begin
                dly++;
            end
        end
    end

    // Byte monitor: order/value, low time before each request, stability.
    initial begin
        logic       prev_req = 1'b0;
        int         low_cnt  = 0;
        bit         first    = 1;
        logic [8:0] last_got = '0;
        logic [8:0] got;
        int         need;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req = 1'b0;
                low_cnt  = 0;
                first    = 1;
            end else begin
                got = {lcd_rs_o, lcd_data_o};
                if (lcd_req_o && !prev_req) begin
                    if (exp_q.size() == 0) chk("exp_q_size", exp_q.size(), 1);
                    else chk("byte", got, exp_q.pop_front());
                    need = first ? POR_CYC : gap_need(last_got);
                    if (low_cnt < need) chk("gap_cycles", low_cnt, need);
                    else chk("gap_ok", 32'(low_cnt >= need), 1);
                    first    = 0;
                    last_got = got;
                    low_cnt  = 0;
                end else if (lcd_req_o) begin
                    chk("stable", got, last_got);
                end else begin
                    low_cnt++;
                end
                prev_req = lcd_req_o;
            end
        end
    end

    task automatic push(input logic rs, input logic [7:0] b, input bit modeled);
        wr_en_i   = 1'b1;
        wr_data_i = {rs, b};
        @(negedge clk);
        wr_en_i   = 1'b0;
        if (modeled) model_byte(rs, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && !lcd_req_o && fifo_level_o == 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < 5000), 1);
        repeat (CLR_CYC + 10) @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!lcd_req_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("req_in_time", 32'(lcd_req_o), 1);
    endtask

    task automatic model_reset();
        logic [7:0] init_seq [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};
        exp_q.delete();
        m_col  = 0;
        m_line = 0;
        foreach (init_seq[i]) model_byte(1'b0, init_seq[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, lcd_req_o, 0);
        chk({tag, "_init_done"}, init_done_o, 0);
        chk({tag, "_level"}, fifo_level_o, 0);
        chk({tag, "_full"}, fifo_full_o, 0);
        chk({tag, "_ovf"}, overflow_o, 0);
        chk({tag, "_data"}, {lcd_rs_o, lcd_data_o}, 0);
    endtask

    initial begin
        logic [7:0] b;
        int         len;
        reset = 1'b0;
        wr_en_i = 1'b0;
        wr_data_i = '0;
        flush_i = 1'b0;
        auto_done = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        model_reset();
        reset = 1'b1;
        wait_idle();
        chk("init_done", init_done_o, 1);

        for (int i = 0; i < 17; i++) push(1'b1, 8'(8'h41 + i), 1);
        wait_idle();

        push(1'b0, 8'hC5, 1);
        for (int i = 0; i < 11; i++) push(1'b1, 8'(8'h61 + i), 1);
        wait_idle();

        auto_done = 0;
        push(1'b1, 8'h58, 1);
        wait_req();
        for (int i = 0; i < D + 1; i++) push(1'b1, 8'(8'h30 + i), 0);
        chk("full", fifo_full_o, 1);
        chk("level_full", fifo_level_o, D);
        chk("overflow", overflow_o, 1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_level", fifo_level_o, 0);
        chk("flush_ovf", overflow_o, 0);
        chk("held_req", lcd_req_o, 1);
        flush_i = 1'b1;
        wr_en_i = 1'b1;
        wr_data_i = 9'h142;
        @(negedge clk);
        flush_i = 1'b0;
        wr_en_i = 1'b0;
        chk("flush_wr_level", fifo_level_o, 0);
        chk("flush_wr_ovf", overflow_o, 0);
        push(1'b1, 8'h59, 1);
        chk("push_visible", fifo_level_o, 1);
        auto_done = 1;
        wait_idle();

        push(1'b0, 8'h01, 1);
        push(1'b1, 8'h5A, 1);
        wait_idle();

        for (int k = 0; k < 20; k++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    push(1'b1, 8'(8'h41 + $urandom_range(0, 25)), 1);
                end else begin
                    case ($urandom_range(0, 5))
                        0: b = 8'h01;
                        1: b = 8'h02;
                        2: b = 8'(8'h80 + $urandom_range(0, 15));
                        3: b = 8'(8'hC0 + $urandom_range(0, 15));
                        default: b = 8'(8'h04 + $urandom_range(0, 59));
                    endcase
                    push(1'b0, b, 1);
                end
                if ($urandom_range(0, 2) == 0) @(negedge clk);
            end
            wait_idle();
        end
        chk("no_overflow", overflow_o, 0);

        push(1'b1, 8'h5A, 1);
        wait_req();
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        wait_idle();
        chk("reinit_done", init_done_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
